adder_hex_display: RTL and testbench

Parametrised adder-to-display block: captures the sum of two WIDTH-bit operands on a load strobe and drives a time-multiplexed, common-anode seven-segment display in hexadecimal. The carry-out lights the decimal point of the most significant digit. It sits between the operand switches/registers and the board's seven-segment pins. It replaces the single-digit combinational adder/decoder pair with a registered, scanned, multi-digit version.

---
 rtl/adder_hex_display.sv | 203 ++++++++++++++++++++
 tb/tb_adder_hex_display.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_hex_display.sv
// ============================================================================
// adder_hex_display
// ----------------------------------------------------------------------------
// Captures the (WIDTH+1)-bit sum of two WIDTH-bit operands on a load strobe
// and shows it in hexadecimal on a time-multiplexed, common-anode
// seven-segment display. The carry-out lights the decimal point of the most
// significant digit.
//
// Parameters:
//   WIDTH        operand width in bits (4..32)
//   REFRESH_DIV  clock cycles each digit stays enabled (>= 2)
//   DIGITS       derived: number of hex digits, (WIDTH+3)/4
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a, b       WIDTH-bit operands
//   load       capture a+b at the rising edge where it is high
//   seg        active-low segments {g,f,e,d,c,b,a}, seg[0] = a (registered)
//   dp         active-low decimal point, carry on the top digit (registered)
//   an         active-low digit enables, an[0] = least significant digit
//              (registered)
//   sum_valid  high once at least one sum has been captured
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero nibble of the sum are blanked (digit 0 is
//                          never blanked; dp on the top digit still shows
//                          the carry).
// ============================================================================
module adder_hex_display #(
    parameter int  WIDTH       = 8,
    parameter int  REFRESH_DIV = 50000,
    localparam int DIGITS      = (WIDTH + 3) / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              load,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              sum_valid
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PAD_W = 4 * DIGITS;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH:0]        sum_r;        // {carry, sum}
    logic                  sum_valid_r;
    logic [PRE_W-1:0]      pre_r;
    logic [IDX_W-1:0]      idx_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [DIGITS-1:0]     an_r;

    logic                  pre_wrap_s;
    logic [PRE_W-1:0]      pre_next_s;
    logic [IDX_W-1:0]      idx_next_s;
    logic [PAD_W-1:0]      pad_s;
    logic [3:0]            nibble_s;
    logic                  blank_s;
    logic                  top_s;
    logic [6:0]            seg_next_s;
    logic                  dp_next_s;
    logic [DIGITS-1:0]     an_next_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0]      msd_s;
`endif

    // Sum capture: load recaptures every cycle it is held high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= {(WIDTH+1){1'b0}};
            sum_valid_r <= 1'b0;
        end else if (load) begin
            sum_r       <= {1'b0, a} + {1'b0, b};
            sum_valid_r <= 1'b1;
        end
    end

    // Prescaler and digit index next-state.
    always_comb begin
        pre_wrap_s = (pre_r == PRE_LAST);
        pre_next_s = pre_r;
        idx_next_s = idx_r;
        if (pre_wrap_s) begin
            pre_next_s = {PRE_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_next_s = {IDX_W{1'b0}};
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            pre_next_s = pre_r + PRE_W'(1);
            idx_next_s = idx_r;
        end
    end

    // Prescaler and digit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= {PRE_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else begin
            pre_r <= pre_next_s;
            idx_r <= idx_next_s;
        end
    end

    // Next display pattern for the digit currently selected by idx_r.
    // Outputs are built only from registered state, so a digit switch or a
    // new capture shows up one edge later as a whole, never mixed.
    always_comb begin
        // Zero-extend the sum (carry excluded) to whole nibbles so a partial
        // top digit reads its missing upper bits as 0.
        pad_s    = PAD_W'(sum_r[WIDTH-1:0]);
        nibble_s = 4'(pad_s >> {idx_r, 2'b00});
        top_s    = (idx_r == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
        // Highest nonzero digit; stays 0 for an all-zero sum so digit 0
        // always shows.
        msd_s = {IDX_W{1'b0}};
        for (int i = 1; i < DIGITS; i++) begin
            msd_s = (pad_s[4*i +: 4] != 4'h0) ? IDX_W'(i) : msd_s;
        end
        blank_s = (idx_r > msd_s);
`else
        blank_s = 1'b0;
`endif

        if (!sum_valid_r || blank_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = hex_to_seg(nibble_s);
        end

        // The carry dot stays on the top digit even when that digit is blank.
        if (sum_valid_r && top_s) begin
            dp_next_s = ~sum_r[WIDTH];
        end else begin
            dp_next_s = 1'b1;
        end

        for (int i = 0; i < DIGITS; i++) begin
            an_next_s[i] = (idx_r == IDX_W'(i)) ? 1'b0 : 1'b1;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
            an_r  <= {DIGITS{1'b1}};
        end else begin
            seg_r <= seg_next_s;
            dp_r  <= dp_next_s;
            an_r  <= an_next_s;
        end
    end

    assign seg       = seg_r;
    assign dp        = dp_r;
    assign an        = an_r;
    assign sum_valid = sum_valid_r;

endmodule

// File: tb/tb_adder_hex_display.sv
// ============================================================================
// tb_adder_hex_display
// ----------------------------------------------------------------------------
// Drives an 8-bit and a 6-bit instance (both REFRESH_DIV=4) with the same
// load strobe. Each driven cycle pushes the expected post-edge outputs of
// both instances to a queue; a monitor pops and compares at the falling
// edge. Scenario tasks add direct checks against literal glyph values.
// ============================================================================
module tb_adder_hex_display;

    localparam int RD = 4;

    typedef struct {
        int         k;
        logic [6:0] seg8;
        logic       dp8;
        logic [1:0] an8;
        logic [6:0] seg6;
        logic       dp6;
        logic [1:0] an6;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] a8, b8;
    logic [5:0] a6, b6;
    logic [6:0] seg8, seg6;
    logic       dp8, dp6;
    logic [1:0] an8, an6;
    logic       sv8, sv6;

    exp_t       sb_q[$];
    int         vec_cnt;
    int         err_cnt;
    int         edges;
    logic [8:0] m_sum8;
    logic [6:0] m_sum6;
    logic       m_valid;

    adder_hex_display #(.WIDTH(8), .REFRESH_DIV(RD)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .load(load),
        .seg(seg8), .dp(dp8), .an(an8), .sum_valid(sv8)
    );

    adder_hex_display #(.WIDTH(6), .REFRESH_DIV(RD)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .a(a6), .b(b6), .load(load),
        .seg(seg6), .dp(dp6), .an(an6), .sum_valid(sv6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            4'hF: return 7'b0001110;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected outputs after edge k, given the captured state before it.
    function automatic exp_t predict(input int k, input logic [8:0] s8,
                                     input logic [6:0] s6, input logic v,
                                     input logic ld);
        exp_t e;
        int   d;
        logic lzb;
`ifdef LEADING_ZERO_BLANK_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        d     = ((k - 1) / RD) % 2;
        e.k   = k;
        e.an8 = (d == 1) ? 2'b01 : 2'b10;
        e.an6 = e.an8;
        e.v   = v | ld;
        if (!v) begin
            e.seg8 = 7'h7F; e.seg6 = 7'h7F; e.dp8 = 1'b1; e.dp6 = 1'b1;
        end else begin
            e.seg8 = glyph((d == 1) ? s8[7:4] : s8[3:0]);
            if (lzb && d == 1 && s8[7:4] == 4'h0) e.seg8 = 7'h7F;
            e.seg6 = glyph((d == 1) ? {2'b00, s6[5:4]} : s6[3:0]);
            if (lzb && d == 1 && s6[5:4] == 2'b00) e.seg6 = 7'h7F;
            e.dp8 = (d == 1) ? ~s8[8] : 1'b1;
            e.dp6 = (d == 1) ? ~s6[6] : 1'b1;
        end
        return e;
    endfunction

    // One clock: drive inputs, push expectation, advance the bench's model.
    task automatic cycle(input logic ld, input logic [7:0] av, input logic [7:0] bv);
        load = ld; a8 = av; b8 = bv; a6 = av[5:0]; b6 = bv[5:0];
        sb_q.push_back(predict(edges + 1, m_sum8, m_sum6, m_valid, ld));
        @(posedge clk);
        edges++;
        if (ld) begin
            m_sum8  = {1'b0, av} + {1'b0, bv};
            m_sum6  = {1'b0, av[5:0]} + {1'b0, bv[5:0]};
            m_valid = 1'b1;
        end
        @(negedge clk);
        #2;
    endtask

    // Idle until the outputs show digit d.
    task automatic advance_to_digit(input int d);
        for (int i = 0; i < 2 * RD; i++) begin
            if (!(edges > 0 && ((edges - 1) / RD) % 2 == d)) cycle(1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic model_reset();
        edges = 0; m_sum8 = 9'h000; m_sum6 = 7'h00; m_valid = 1'b0;
    endtask

    // Scoreboard monitor: one expectation per driven edge.
    initial begin : sb_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vec_cnt += 8;
                if (seg8 !== e.seg8) begin err_cnt++; $display("FAIL sb_seg8 edge %0d: got %b expected %b", e.k, seg8, e.seg8); end
                if (dp8  !== e.dp8)  begin err_cnt++; $display("FAIL sb_dp8 edge %0d: got %b expected %b", e.k, dp8, e.dp8); end
                if (an8  !== e.an8)  begin err_cnt++; $display("FAIL sb_an8 edge %0d: got %b expected %b", e.k, an8, e.an8); end
                if (sv8  !== e.v)    begin err_cnt++; $display("FAIL sb_valid8 edge %0d: got %b expected %b", e.k, sv8, e.v); end
                if (seg6 !== e.seg6) begin err_cnt++; $display("FAIL sb_seg6 edge %0d: got %b expected %b", e.k, seg6, e.seg6); end
                if (dp6  !== e.dp6)  begin err_cnt++; $display("FAIL sb_dp6 edge %0d: got %b expected %b", e.k, dp6, e.dp6); end
                if (an6  !== e.an6)  begin err_cnt++; $display("FAIL sb_an6 edge %0d: got %b expected %b", e.k, an6, e.an6); end
                if (sv6  !== e.v)    begin err_cnt++; $display("FAIL sb_valid6 edge %0d: got %b expected %b", e.k, sv6, e.v); end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; a8 = 8'h00; b8 = 8'h00; a6 = 6'h00; b6 = 6'h00;
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        vec_cnt += 5;
        if (seg8 !== 7'h7F) begin err_cnt++; $display("FAIL reset_seg: got %h expected 7f", seg8); end
        if (dp8 !== 1'b1)   begin err_cnt++; $display("FAIL reset_dp: got %b expected 1", dp8); end
        if (an8 !== 2'b11)  begin err_cnt++; $display("FAIL reset_an: got %b expected 11", an8); end
        if (sv8 !== 1'b0)   begin err_cnt++; $display("FAIL reset_valid: got %b expected 0", sv8); end
        if (an6 !== 2'b11)  begin err_cnt++; $display("FAIL reset_an6: got %b expected 11", an6); end
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 8'h00, 8'h00);
        vec_cnt++;
        if (an8 !== 2'b10) begin err_cnt++; $display("FAIL idle_an_d0: got %b expected 10", an8); end
        cycle(1'b0, 8'h00, 8'h00);
        vec_cnt++;
        if (an8 !== 2'b01) begin err_cnt++; $display("FAIL idle_an_d1: got %b expected 01", an8); end
        repeat (7) cycle(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_add_basic();
        cycle(1'b1, 8'h3C, 8'h05);
        vec_cnt++;
        if (sv8 !== 1'b1) begin err_cnt++; $display("FAIL add_valid: got %b expected 1", sv8); end
        cycle(1'b0, 8'h00, 8'h00);
        advance_to_digit(0);
        vec_cnt += 2;
        if (seg8 !== 7'b1111001) begin err_cnt++; $display("FAIL add_d0_seg: got %b expected 1111001", seg8); end
        if (dp8 !== 1'b1)        begin err_cnt++; $display("FAIL add_d0_dp: got %b expected 1", dp8); end
        advance_to_digit(1);
        vec_cnt += 2;
        if (seg8 !== 7'b0011001) begin err_cnt++; $display("FAIL add_d1_seg: got %b expected 0011001", seg8); end
        if (dp8 !== 1'b1)        begin err_cnt++; $display("FAIL add_d1_dp: got %b expected 1", dp8); end
    endtask

    task automatic test_carry();
        cycle(1'b1, 8'hFF, 8'hFF);
        cycle(1'b0, 8'h00, 8'h00);
        advance_to_digit(0);
        vec_cnt += 2;
        if (seg8 !== 7'b0000110) begin err_cnt++; $display("FAIL carry_d0_seg: got %b expected 0000110", seg8); end
        if (dp8 !== 1'b1)        begin err_cnt++; $display("FAIL carry_d0_dp: got %b expected 1", dp8); end
        advance_to_digit(1);
        vec_cnt += 2;
        if (seg8 !== 7'b0001110) begin err_cnt++; $display("FAIL carry_d1_seg: got %b expected 0001110", seg8); end
        if (dp8 !== 1'b0)        begin err_cnt++; $display("FAIL carry_d1_dp: got %b expected 0", dp8); end
    endtask

    task automatic test_zero();
        logic [6:0] hi_exp;
`ifdef LEADING_ZERO_BLANK_EN
        hi_exp = 7'h7F;
`else
        hi_exp = 7'b1000000;
`endif
        cycle(1'b1, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00);
        advance_to_digit(0);
        vec_cnt++;
        if (seg8 !== 7'b1000000) begin err_cnt++; $display("FAIL zero_d0_seg: got %b expected 1000000", seg8); end
        advance_to_digit(1);
        vec_cnt++;
        if (seg8 !== hi_exp) begin err_cnt++; $display("FAIL zero_d1_seg: got %b expected %b", seg8, hi_exp); end
    endtask

    task automatic test_width6();
        logic [6:0] hi_exp;
`ifdef LEADING_ZERO_BLANK_EN
        hi_exp = 7'h7F;
`else
        hi_exp = 7'b1000000;
`endif
        cycle(1'b1, 8'h3F, 8'h01);
        cycle(1'b0, 8'h00, 8'h00);
        advance_to_digit(0);
        vec_cnt++;
        if (seg6 !== 7'b1000000) begin err_cnt++; $display("FAIL w6_d0_seg: got %b expected 1000000", seg6); end
        advance_to_digit(1);
        vec_cnt += 2;
        if (seg6 !== hi_exp) begin err_cnt++; $display("FAIL w6_d1_seg: got %b expected %b", seg6, hi_exp); end
        if (dp6 !== 1'b0)    begin err_cnt++; $display("FAIL w6_d1_dp: got %b expected 0", dp6); end
    endtask

    task automatic test_load_on_switch();
        // Stop right before an edge where the index moves from digit 0 to 1.
        for (int i = 0; i < 2 * RD; i++) begin
            if ((edges + 1) % (2 * RD) != RD) cycle(1'b0, 8'h00, 8'h00);
        end
        cycle(1'b1, 8'h5A, 8'h21);
        cycle(1'b0, 8'h00, 8'h00);
        vec_cnt += 3;
        if (an8 !== 2'b01)       begin err_cnt++; $display("FAIL switch_an: got %b expected 01", an8); end
        if (seg8 !== 7'b1111000) begin err_cnt++; $display("FAIL switch_seg: got %b expected 1111000", seg8); end
        if (dp8 !== 1'b1)        begin err_cnt++; $display("FAIL switch_dp: got %b expected 1", dp8); end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 8'h11, 8'h22);
        cycle(1'b1, 8'h33, 8'h44);
        cycle(1'b1, 8'h80, 8'h80);
        cycle(1'b0, 8'h00, 8'h00);
        advance_to_digit(1);
        vec_cnt++;
        if (dp8 !== 1'b0) begin err_cnt++; $display("FAIL b2b_d1_dp: got %b expected 0", dp8); end
        repeat (8) cycle(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 8'h05);
        for (int i = 0; i < 8; i++) begin
            if (edges < RD + 2) cycle(1'b0, 8'h00, 8'h00);
        end
        // Second cycle of digit 1, with a capture pending on the next edge.
        load = 1'b1; a8 = 8'hFF; b8 = 8'hFF; a6 = 6'h3F; b6 = 6'h3F;
        rst_n = 1'b0;
        #1;
        vec_cnt += 6;
        if (seg8 !== 7'h7F) begin err_cnt++; $display("FAIL midrst_seg: got %h expected 7f", seg8); end
        if (an8 !== 2'b11)  begin err_cnt++; $display("FAIL midrst_an: got %b expected 11", an8); end
        if (sv8 !== 1'b0)   begin err_cnt++; $display("FAIL midrst_valid: got %b expected 0", sv8); end
        if (dp8 !== 1'b1)   begin err_cnt++; $display("FAIL midrst_dp: got %b expected 1", dp8); end
        if (seg6 !== 7'h7F) begin err_cnt++; $display("FAIL midrst_seg6: got %h expected 7f", seg6); end
        if (an6 !== 2'b11)  begin err_cnt++; $display("FAIL midrst_an6: got %b expected 11", an6); end
        model_reset();
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, 8'h00);
        vec_cnt += 2;
        if (an8 !== 2'b10)  begin err_cnt++; $display("FAIL restart_an: got %b expected 10", an8); end
        if (seg8 !== 7'h7F) begin err_cnt++; $display("FAIL restart_seg: got %h expected 7f", seg8); end
        repeat (9) cycle(1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_add_basic();
        test_carry();
        test_zero();
        test_width6();
        test_load_on_switch();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        #2;
        vec_cnt++;
        if (sb_q.size() != 0) begin err_cnt++; $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
